alu_n_flag: RTL and testbench
=============================

Name: alu_n_flag

Overview:
- 16-bit, 8-operation ALU with a registered 3-bit status flag register (Zero, Overflow, Negative).
- Sits in the EX stage of the 5-stage pipeline core.
- The result is combinational. Flags are captured on the clock edge only when the instruction is allowed to modify them, so later branch logic sees the last flag-setting result.

Parameters:
- DATA_W, 16, operand/result width; flag rules below are written for 16 and bit DATA_W-1 is the sign bit.
- SHAMT_W, 4, shift-amount width; must equal log2(DATA_W).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset: asserted when low, released when high.
- A  input  DATA_W  operand A; also the shift/rotate source.
- B  input  DATA_W  operand B; ignored by ops 4-7.
- op  input  3  operation select.
- imm  input  SHAMT_W  shift/rotate amount.
- modify  input  1  flag write enable.
- result  output  DATA_W  combinational ALU result.
- outFlag  output  3  registered flags: {Z, V, N} = bit2 zero, bit1 overflow, bit0 negative.

Behaviour:
- Op encoding:
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND.
  - 3 OR.
  - 4 SLL: A<<imm.
  - 5 SRL: A>>imm, logical.
  - 6 SRA: A>>>imm, sign-filled.
  - 7 ROL: A rotated left by imm.
- All arithmetic is modulo 2^DATA_W; no carry output.
- result is purely combinational from A, B, op, imm, with zero latency.
- imm = 0 gives result = A for ops 4-7.
- Next-flag computation (combinational):
  - Z = (result == 0), for every op.
  - ADD: V = A[15]==B[15] && result[15]!=A[15].
  - SUB: V = A[15]!=B[15] && result[15]!=A[15].
  - ADD/SUB: N = result[15] & ~V. Negative is suppressed when overflow is set, because the sign bit is then invalid.
  - Ops 2-7: V = 0 and N = 0. Logic and shift results are never reported negative.
  - Z and V can both be 1, e.g. 8000h+8000h gives flags 110.
- Flag register:
  - On rising clk with modify=1, outFlag <= next flags.
  - With modify=0, outFlag holds its value regardless of op or operands.
- Reset: rst low asynchronously forces outFlag = 000 and holds it while low. rst has priority over modify, including mid-operation.
- After rst releases, the first rising edge with modify=1 loads flags normally.
- Latency: outFlag reflects the operands present at the capturing edge, one cycle after they are applied.

Optional Feature:
- Macro: ALU_FLAG_NEXT_EN.
- When defined: add output port flag_next (3 bits), driving the combinational next-flag value {Z,V,N} ungated by modify. It is used for same-cycle branch resolution.
- When undefined: the port does not exist. Behaviour of result and outFlag is identical in both builds.

Test Plan:
- Reset: rst low, then high; outFlag = 000. Apply A=FFFF, B=0000, op=2, modify=1; after the edge, outFlag = 100.
- Logic ops with modify=1:
  - AND FFFF&FFFF -> 000.
  - OR 0000|0000 -> 100.
  - OR FFFF|FFFF -> 000 (N never set for logic).
- ADD with modify=1:
  - 0001+FFFF -> 100.
  - FFFE+0001 -> 001.
  - 8001+8001 -> 010 (result 0002).
  - 7FFF+7FFF -> 010 (result FFFE; N suppressed by V).
- SUB with modify=1:
  - 0001-0001 -> 100.
  - 0000-0001 -> 001.
  - 8000-0FFF -> 010.
  - 0FFF-8000 -> 010 (result 8FFF).
- Hold with modify=0 after flags = 010; outFlag stays 010 across all of:
  - SLL 000A by 4: result 00A0.
  - SRL 000B by 3: result 0001.
  - SRA 003C by 2: result 000F.
  - ROL F000 by 1: result E001.
  - SRA F000 by 2: result FC00.
- Async reset mid-stream: with flags = 010 and modify=1, pull rst low between edges; outFlag = 000 immediately and stays 000 across edges until rst releases.

Source files
------------

// File: rtl/alu_n_flag.sv
// 16-bit, 8-operation EX-stage ALU with a combinational result and a registered {Z,V,N} flag register.
// Optional macro ALU_FLAG_NEXT_EN exposes the ungated next-flag value on port flag_next.
module alu_n_flag #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  A,
  input  logic [DATA_W-1:0]  B,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] imm,
  input  logic               modify,
  output logic [DATA_W-1:0]  result,
`ifdef ALU_FLAG_NEXT_EN
  output logic [2:0]         flag_next,
`endif
  output logic [2:0]         outFlag
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SRL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_ROL = 3'd7;

  logic [DATA_W-1:0]   sum_s;
  logic [DATA_W-1:0]   diff_s;
  logic [DATA_W-1:0]   sra_s;
  logic [2*DATA_W-1:0] rot_s;
  logic [DATA_W-1:0]   result_s;
  logic                zero_s;
  logic                ovf_s;
  logic                neg_s;
  logic [2:0]          flag_next_s;
  logic [2:0]          flag_r;

  assign sum_s  = A + B;
  assign diff_s = A - B;
  assign sra_s  = DATA_W'($signed(A) >>> imm);
  // Rotating a doubled copy keeps imm = 0 well defined without a width-sized shift.
  assign rot_s  = {A, A} << imm;

  // Result multiplexer, purely combinational.
  always_comb begin
    result_s = {DATA_W{1'b0}};
    case (op)
      OP_ADD:  result_s = sum_s;
      OP_SUB:  result_s = diff_s;
      OP_AND:  result_s = A & B;
      OP_OR:   result_s = A | B;
      OP_SLL:  result_s = A << imm;
      OP_SRL:  result_s = A >> imm;
      OP_SRA:  result_s = sra_s;
      OP_ROL:  result_s = rot_s[2*DATA_W-1:DATA_W];
      default: result_s = {DATA_W{1'b0}};
    endcase
  end

  assign result = result_s;
  assign zero_s = (result_s == {DATA_W{1'b0}});

  // Next-flag computation; negative is suppressed whenever overflow makes the sign bit invalid.
  always_comb begin
    ovf_s = 1'b0;
    neg_s = 1'b0;
    case (op)
      OP_ADD: begin
        ovf_s = (A[DATA_W-1] == B[DATA_W-1]) && (result_s[DATA_W-1] != A[DATA_W-1]);
        neg_s = result_s[DATA_W-1] & ~ovf_s;
      end
      OP_SUB: begin
        ovf_s = (A[DATA_W-1] != B[DATA_W-1]) && (result_s[DATA_W-1] != A[DATA_W-1]);
        neg_s = result_s[DATA_W-1] & ~ovf_s;
      end
      default: begin
        ovf_s = 1'b0;
        neg_s = 1'b0;
      end
    endcase
  end

  assign flag_next_s = {zero_s, ovf_s, neg_s};

  // Flag register: loads only on flag-setting instructions, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_r <= 3'b000;
    end else if (modify) begin
      flag_r <= flag_next_s;
    end else begin
      flag_r <= flag_r;
    end
  end

  assign outFlag = flag_r;

`ifdef ALU_FLAG_NEXT_EN
  assign flag_next = flag_next_s;
`endif

endmodule

// File: tb/tb_alu_n_flag.sv
// Directed self-checking bench for alu_n_flag: reset, logic, add, sub, shift hold and async reset.
module tb_alu_n_flag;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  op;
  logic [3:0]  imm;
  logic        modify;
  logic [15:0] result;
  logic [2:0]  outFlag;
`ifdef ALU_FLAG_NEXT_EN
  logic [2:0]  flag_next;
`endif

  int checks = 0;
  int errors = 0;

  alu_n_flag dut (
    .clk(clk),
    .rst(rst),
    .A(A),
    .B(B),
    .op(op),
    .imm(imm),
    .modify(modify),
    .result(result),
`ifdef ALU_FLAG_NEXT_EN
    .flag_next(flag_next),
`endif
    .outFlag(outFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                       input logic [3:0] i, input logic m);
    @(negedge clk);
    A = a; B = b; op = o; imm = i; modify = m;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    A = 16'h0000; B = 16'h0000; op = 3'd0; imm = 4'd0; modify = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outFlag !== 3'b000) begin
      errors++; $display("FAIL reset_low outFlag=%b expected=%b", outFlag, 3'b000);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (outFlag !== 3'b000) begin
      errors++; $display("FAIL reset_release outFlag=%b expected=%b", outFlag, 3'b000);
    end
    drive(16'hFFFF, 16'h0000, 3'd2, 4'd0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (outFlag !== 3'b100) begin
      errors++; $display("FAIL reset_first_load outFlag=%b expected=%b", outFlag, 3'b100);
    end
  endtask

  task automatic test_logic;
    logic [15:0] va [3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    logic [15:0] vb [3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    logic [2:0]  vo [3] = '{3'd2, 3'd3, 3'd3};
    logic [15:0] vr [3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    logic [2:0]  vf [3] = '{3'b000, 3'b100, 3'b000};
    for (int k = 0; k < 3; k++) begin
      drive(va[k], vb[k], vo[k], 4'd0, 1'b1);
      #1;
      checks++;
      if (result !== vr[k]) begin
        errors++; $display("FAIL logic_result[%0d] result=%h expected=%h", k, result, vr[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (outFlag !== vf[k]) begin
        errors++; $display("FAIL logic_flags[%0d] outFlag=%b expected=%b", k, outFlag, vf[k]);
      end
    end
  endtask

  task automatic test_add;
    logic [15:0] va [5] = '{16'h0001, 16'hFFFE, 16'h8001, 16'h7FFF, 16'h8000};
    logic [15:0] vb [5] = '{16'hFFFF, 16'h0001, 16'h8001, 16'h7FFF, 16'h8000};
    logic [15:0] vr [5] = '{16'h0000, 16'hFFFF, 16'h0002, 16'hFFFE, 16'h0000};
    logic [2:0]  vf [5] = '{3'b100, 3'b001, 3'b010, 3'b010, 3'b110};
    for (int k = 0; k < 5; k++) begin
      drive(va[k], vb[k], 3'd0, 4'd0, 1'b1);
      #1;
      checks++;
      if (result !== vr[k]) begin
        errors++; $display("FAIL add_result[%0d] result=%h expected=%h", k, result, vr[k]);
      end
`ifdef ALU_FLAG_NEXT_EN
      checks++;
      if (flag_next !== vf[k]) begin
        errors++; $display("FAIL add_flag_next[%0d] flag_next=%b expected=%b", k, flag_next, vf[k]);
      end
`endif
      @(posedge clk); #1;
      checks++;
      if (outFlag !== vf[k]) begin
        errors++; $display("FAIL add_flags[%0d] outFlag=%b expected=%b", k, outFlag, vf[k]);
      end
    end
  endtask

  task automatic test_sub;
    logic [15:0] va [4] = '{16'h0001, 16'h0000, 16'h8000, 16'h0FFF};
    logic [15:0] vb [4] = '{16'h0001, 16'h0001, 16'h0FFF, 16'h8000};
    logic [15:0] vr [4] = '{16'h0000, 16'hFFFF, 16'h7001, 16'h8FFF};
    logic [2:0]  vf [4] = '{3'b100, 3'b001, 3'b010, 3'b010};
    for (int k = 0; k < 4; k++) begin
      drive(va[k], vb[k], 3'd1, 4'd0, 1'b1);
      #1;
      checks++;
      if (result !== vr[k]) begin
        errors++; $display("FAIL sub_result[%0d] result=%h expected=%h", k, result, vr[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (outFlag !== vf[k]) begin
        errors++; $display("FAIL sub_flags[%0d] outFlag=%b expected=%b", k, outFlag, vf[k]);
      end
    end
  endtask

  // Flags are 010 on entry (last SUB); shifts with modify=0 must not disturb them.
  task automatic test_hold;
    logic [15:0] va [6] = '{16'h000A, 16'h000B, 16'h003C, 16'hF000, 16'hF000, 16'h1234};
    logic [2:0]  vo [6] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd7};
    logic [3:0]  vi [6] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd2, 4'd0};
    logic [15:0] vr [6] = '{16'h00A0, 16'h0001, 16'h000F, 16'hE001, 16'hFC00, 16'h1234};
    for (int k = 0; k < 6; k++) begin
      drive(va[k], 16'h0000, vo[k], vi[k], 1'b0);
      #1;
      checks++;
      if (result !== vr[k]) begin
        errors++; $display("FAIL shift_result[%0d] result=%h expected=%h", k, result, vr[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (outFlag !== 3'b010) begin
        errors++; $display("FAIL hold_flags[%0d] outFlag=%b expected=%b", k, outFlag, 3'b010);
      end
    end
    // Shift with modify=1: sign bit set in result but N is never reported for shifts.
    drive(16'hF000, 16'h0000, 3'd6, 4'd2, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (outFlag !== 3'b000) begin
      errors++; $display("FAIL shift_flags outFlag=%b expected=%b", outFlag, 3'b000);
    end
  endtask

  task automatic test_async_reset;
    drive(16'h7FFF, 16'h7FFF, 3'd0, 4'd0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (outFlag !== 3'b010) begin
      errors++; $display("FAIL async_setup outFlag=%b expected=%b", outFlag, 3'b010);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (outFlag !== 3'b000) begin
      errors++; $display("FAIL async_immediate outFlag=%b expected=%b", outFlag, 3'b000);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (outFlag !== 3'b000) begin
        errors++; $display("FAIL async_held[%0d] outFlag=%b expected=%b", k, outFlag, 3'b000);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (outFlag !== 3'b010) begin
      errors++; $display("FAIL async_reload outFlag=%b expected=%b", outFlag, 3'b010);
    end
  endtask

  initial begin
    test_reset;
    test_logic;
    test_add;
    test_sub;
    test_hold;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
